// File: rtl/interval_sequencer.sv
// interval_sequencer: steps through a rewritable table of segment terminal counts, timing each segment.
// Optional pause input enabled by defining INTERVAL_SEQUENCER_PAUSE_EN.
module interval_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          cfg_last_we,
    input  logic [AW-1:0] cfg_last,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
`ifdef INTERVAL_SEQUENCER_PAUSE_EN
    input  logic          pause,
`endif
    output logic          busy,
    output logic          cnt_en,
    output logic [AW-1:0] seg_idx,
    output logic [CW-1:0] count,
    output logic          seg_done,
    output logic          seq_done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] tbl_q [DEPTH];
    logic [CW-1:0] tbl_d [DEPTH];
    logic [AW-1:0] seg_idx_q, seg_idx_d, last_q, last_d;
    logic [CW-1:0] count_q, count_d;
    logic          loop_q, loop_d;
    logic          run, hold, at_last;

    function automatic logic [CW-1:0] init_val(input int i);
        return i == 0 ? CW'(12) : i == 1 ? CW'(3) : i == 2 ? CW'(1) :
               i == 3 ? CW'(5)  : i == 4 ? CW'(10) : '0;
    endfunction

`ifdef INTERVAL_SEQUENCER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign run      = state_q == RUN;
    assign at_last  = seg_idx_q == last_q;
    assign busy     = run;
    assign cnt_en   = run && !hold;
    assign seg_idx  = seg_idx_q;
    assign count    = count_q;
    // stop and pause both mask the terminal event
    assign seg_done = run && !stop && !hold && count_q == tbl_q[seg_idx_q];
    assign seq_done = seg_done && at_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            seg_idx_q <= '0;
            count_q   <= '0;
            last_q    <= AW'(4);
            loop_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= init_val(i);
        end else begin
            state_q   <= state_d;
            seg_idx_q <= seg_idx_d;
            count_q   <= count_d;
            last_q    <= last_d;
            loop_q    <= loop_d;
            tbl_q     <= tbl_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        count_d   = count_q;
        last_d    = last_q;
        loop_d    = loop_q;
        tbl_d     = tbl_q;
        if (!run) begin
            if (cfg_we) tbl_d[cfg_addr] = cfg_data;
            if (cfg_last_we) last_d = cfg_last;
            if (start && !stop) begin
                state_d   = RUN;
                seg_idx_d = '0;
                count_d   = '0;
                loop_d    = loop;
            end
        end else if (stop) begin
            state_d   = IDLE;
            seg_idx_d = '0;
            count_d   = '0;
        end else if (!hold) begin
            count_d = seg_done ? '0 : count_q + CW'(1);
            if (seg_done) begin
                seg_idx_d = at_last ? '0 : seg_idx_q + AW'(1);
                state_d   = at_last && !loop_q ? IDLE : RUN;
            end
        end
    end
endmodule
